// File: rtl/sram_port_arb.sv
// Round-robin arbiter sharing one single-port SRAM bank between REQ_NUM requesters.
// Sequences the 1-cycle read latency and holds read data until the owning requester accepts it.
module sram_port_arb #(
   parameter int REQ_NUM    = 2,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 64
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [REQ_NUM-1:0]                     req_valid_i,
   output logic [REQ_NUM-1:0]                     req_ready_o,
   input  logic [REQ_NUM-1:0]                     req_wen_i,
   input  logic [REQ_NUM-1:0][DATA_WIDTH/8-1:0]   req_bm_i,
   input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]     req_addr_i,
   input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]     req_dat_i,
   output logic [REQ_NUM-1:0]                     rsp_valid_o,
   input  logic [REQ_NUM-1:0]                     rsp_ready_i,
   output logic [DATA_WIDTH-1:0]                  rsp_dat_o,
   output logic                                   sram_en_o,
   output logic                                   sram_wen_o,
   output logic [DATA_WIDTH/8-1:0]                sram_bm_o,
   output logic [ADDR_WIDTH-1:0]                  sram_addr_o,
   output logic [DATA_WIDTH-1:0]                  sram_dat_o,
   input  logic [DATA_WIDTH-1:0]                  sram_dat_i,
   output logic                                   busy_o
);
   localparam int PTR_W = $clog2(REQ_NUM);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] RSP     = 2'd2;

   logic [1:0]       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] rsp_id;
   logic [PTR_W-1:0] win;
   logic [PTR_W:0]   sum;
   logic             found;
   logic             rsp_hs;
   logic             grant_ok;

   assign rsp_hs   = (state == RSP) && rsp_ready_i[rsp_id];
   assign grant_ok = (state == IDLE) || rsp_hs;
   assign busy_o   = (state != IDLE);

   // Scan upward from rr_ptr with wrap; first valid requester wins.
   always_comb begin
      req_ready_o = '0;
      win         = '0;
      found       = 1'b0;
      sum         = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(REQ_NUM))
            sum = sum - (PTR_W+1)'(REQ_NUM);
         if (grant_ok && !found && req_valid_i[sum[PTR_W-1:0]]) begin
            found = 1'b1;
            win   = sum[PTR_W-1:0];
         end
      end
      if (found)
         req_ready_o[win] = 1'b1;
   end

   always_comb begin
      sram_en_o   = found;
      sram_wen_o  = found & req_wen_i[win];
      sram_bm_o   = found ? req_bm_i[win]   : '0;
      sram_addr_o = found ? req_addr_i[win] : '0;
      sram_dat_o  = found ? req_dat_i[win]  : '0;
   end

   always_comb begin
      rsp_valid_o = '0;
      if (state == RSP)
         rsp_valid_o[rsp_id] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         rsp_id    <= '0;
         rsp_dat_o <= '0;
      end else begin
         if (found)
            rr_ptr <= (win == PTR_W'(REQ_NUM-1)) ? '0 : win + PTR_W'(1);
         case (state)
            IDLE, RSP: begin
               // RSP only leaves on the handshake; a read granted in that cycle re-enters RD_WAIT.
               if (grant_ok) begin
                  if (found && !req_wen_i[win]) begin
                     state  <= RD_WAIT;
                     rsp_id <= win;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            RD_WAIT: begin
               rsp_dat_o <= sram_dat_i;
               state     <= RSP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb: cycle vectors with hand-computed expectations
// against a simple behavioural SRAM, plus a mid-read reset sequence.
module tb_sram_port_arb;
   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid, req_ready, req_wen, rsp_valid, rsp_ready;
   logic [1:0][7:0]   req_bm;
   logic [1:0][8:0]   req_addr;
   logic [1:0][63:0]  req_dat;
   logic [63:0]       rsp_dat, sram_wdat, sram_rdat;
   logic              sram_en, sram_wen, busy;
   logic [7:0]        sram_bm;
   logic [8:0]        sram_addr;
   logic [63:0]       mem [512];

   int tests = 0;
   int fails = 0;

   sram_port_arb #(.REQ_NUM(2), .ADDR_WIDTH(9), .DATA_WIDTH(64)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
      .req_bm_i(req_bm), .req_addr_i(req_addr), .req_dat_i(req_dat),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
      .sram_en_o(sram_en), .sram_wen_o(sram_wen), .sram_bm_o(sram_bm),
      .sram_addr_o(sram_addr), .sram_dat_o(sram_wdat), .sram_dat_i(sram_rdat),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM: masked write, read data one cycle after enable.
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_wen) begin
            for (int b = 0; b < 8; b++)
               if (sram_bm[b]) mem[sram_addr][b*8 +: 8] <= sram_wdat[b*8 +: 8];
         end else begin
            sram_rdat <= mem[sram_addr];
         end
      end
   end

   typedef struct {
      logic [1:0]  vld, wen, rdy;
      logic [8:0]  a0, a1;
      logic [63:0] d0, d1;
      logic [7:0]  bm0, bm1;
      logic [1:0]  e_gnt, e_rsp;
      logic        e_busy, e_wen;
      logic [8:0]  e_addr;
      logic [63:0] e_dat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic [1:0] vld, logic [1:0] wen, logic [1:0] rdy,
                              logic [8:0] a0, logic [63:0] d0, logic [7:0] bm0,
                              logic [8:0] a1, logic [63:0] d1, logic [7:0] bm1,
                              logic [1:0] e_gnt, logic e_wen, logic [8:0] e_addr,
                              logic [1:0] e_rsp, logic [63:0] e_dat, logic e_busy);
      vec_t r;
      r.vld = vld; r.wen = wen; r.rdy = rdy;
      r.a0 = a0; r.d0 = d0; r.bm0 = bm0;
      r.a1 = a1; r.d1 = d1; r.bm1 = bm1;
      r.e_gnt = e_gnt; r.e_wen = e_wen; r.e_addr = e_addr;
      r.e_rsp = e_rsp; r.e_dat = e_dat; r.e_busy = e_busy;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      req_valid = '0; req_wen = '0; rsp_ready = '0;
      req_bm = '0; req_addr = '0; req_dat = '0;
   endtask

   localparam logic [63:0] D0  = 64'h1111_0000_0000_0010;
   localparam logic [63:0] D1  = 64'h2222_0000_0000_0020;
   localparam logic [63:0] A5  = 64'hA5A5;
   localparam logic [63:0] ONE = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] BMR = 64'hFFFF_FFFF_0000_0000;
   localparam logic [63:0] D3  = 64'h3333_4444_5555_6666;

   initial begin
      //         vld    wen    rdy    a0  d0   bm0    a1  d1   bm1    gnt   wen  addr rsp    dat  busy
      // Both requesters writing: strict alternation starting with req0, no bubbles.
      vecs.push_back(v(2'b11, 2'b11, 2'b00, 10, D0, 8'hFF, 20, D1, 8'hFF, 2'b01, 1, 10, 2'b00, 0, 0));
      vecs.push_back(v(2'b11, 2'b11, 2'b00, 10, D0, 8'hFF, 20, D1, 8'hFF, 2'b10, 1, 20, 2'b00, 0, 0));
      vecs.push_back(v(2'b11, 2'b11, 2'b00, 10, D0, 8'hFF, 20, D1, 8'hFF, 2'b01, 1, 10, 2'b00, 0, 0));
      vecs.push_back(v(2'b11, 2'b11, 2'b00, 10, D0, 8'hFF, 20, D1, 8'hFF, 2'b10, 1, 20, 2'b00, 0, 0));
      // req0 write 5 then read 5: response two cycles after the read grant.
      vecs.push_back(v(2'b01, 2'b01, 2'b00, 5, A5, 8'hFF, 0, 0, 0, 2'b01, 1, 5, 2'b00, 0, 0));
      vecs.push_back(v(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 0, 0, 2'b01, 0, 5, 2'b00, 0, 0));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, A5, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, A5, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));
      // Byte mask: all-ones, then zero low four bytes, then read back.
      vecs.push_back(v(2'b10, 2'b10, 2'b00, 0, 0, 0, 7, ONE, 8'hFF, 2'b10, 1, 7, 2'b00, 0, 0));
      vecs.push_back(v(2'b10, 2'b10, 2'b00, 0, 0, 0, 7, 0, 8'h0F, 2'b10, 1, 7, 2'b00, 0, 0));
      vecs.push_back(v(2'b10, 2'b00, 2'b00, 0, 0, 0, 7, 0, 0, 2'b10, 0, 7, 2'b00, 0, 0));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b10, BMR, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));
      // req1 read stalled 5 cycles while req0 waits; req0 ready ignored; grant on handshake.
      vecs.push_back(v(2'b10, 2'b00, 2'b00, 0, 0, 0, 20, 0, 0, 2'b10, 0, 20, 2'b00, 0, 0));
      vecs.push_back(v(2'b01, 2'b01, 2'b00, 30, D3, 8'hFF, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(v(2'b01, 2'b01, 2'b01, 30, D3, 8'hFF, 0, 0, 0, 2'b00, 0, 0, 2'b10, D1, 1));
      vecs.push_back(v(2'b01, 2'b01, 2'b10, 30, D3, 8'hFF, 0, 0, 0, 2'b01, 1, 30, 2'b10, D1, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));
      // Read back 30, then back-to-back read granted in the handshake cycle.
      vecs.push_back(v(2'b01, 2'b00, 2'b00, 30, 0, 0, 0, 0, 0, 2'b01, 0, 30, 2'b00, 0, 0));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1));
      vecs.push_back(v(2'b01, 2'b00, 2'b01, 5, 0, 0, 0, 0, 0, 2'b01, 0, 5, 2'b01, D3, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, A5, 1));
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));

      drive_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset req_ready", {62'd0, req_ready}, 0);
      chk("reset rsp_valid", {62'd0, rsp_valid}, 0);
      chk("reset rsp_dat", rsp_dat, 0);
      chk("reset sram_en", {63'd0, sram_en}, 0);
      chk("reset sram_addr", {55'd0, sram_addr}, 0);
      chk("reset busy", {63'd0, busy}, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         req_valid = vecs[i].vld; req_wen = vecs[i].wen; rsp_ready = vecs[i].rdy;
         req_addr[0] = vecs[i].a0; req_dat[0] = vecs[i].d0; req_bm[0] = vecs[i].bm0;
         req_addr[1] = vecs[i].a1; req_dat[1] = vecs[i].d1; req_bm[1] = vecs[i].bm1;
         #1;
         chk($sformatf("v%0d grant", i), {62'd0, req_ready}, {62'd0, vecs[i].e_gnt});
         chk($sformatf("v%0d sram_en", i), {63'd0, sram_en}, {63'd0, |vecs[i].e_gnt});
         chk($sformatf("v%0d sram_wen", i), {63'd0, sram_wen}, {63'd0, vecs[i].e_wen});
         chk($sformatf("v%0d sram_addr", i), {55'd0, sram_addr}, {55'd0, vecs[i].e_addr});
         chk($sformatf("v%0d rsp_valid", i), {62'd0, rsp_valid}, {62'd0, vecs[i].e_rsp});
         if (vecs[i].e_rsp != 2'b00)
            chk($sformatf("v%0d rsp_dat", i), rsp_dat, vecs[i].e_dat);
         chk($sformatf("v%0d busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
      end

      // Reset during RD_WAIT: pointer is 1 beforehand, so a req0 win afterwards shows it cleared.
      @(negedge clk);
      drive_idle();
      req_valid = 2'b01; req_addr[0] = 9'd5;
      #1;
      chk("rst seq read grant", {62'd0, req_ready}, 2'b01);
      @(negedge clk);
      drive_idle();
      #1;
      chk("rst seq in RD_WAIT", {63'd0, busy}, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst async busy", {63'd0, busy}, 0);
      chk("rst async rsp_valid", {62'd0, rsp_valid}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rst no rsp c%0d", c), {62'd0, rsp_valid}, 0);
         chk($sformatf("rst idle busy c%0d", c), {63'd0, busy}, 0);
      end
      @(negedge clk);
      req_valid = 2'b11; req_wen = 2'b11;
      #1;
      chk("rst first grant req0", {62'd0, req_ready}, 2'b01);
      @(negedge clk);
      drive_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
